// File: rtl/fm_sb_capture_seq.sv
`timescale 1ns/1ps
// Spy-buffer capture sequencer: arm, wait for a trigger plus post delay, freeze the
// unmasked buffers, then walk them one at a time through a req/ack readout port.
module fm_sb_capture_seq #(
    parameter int SB_N  = 64,
    parameter int DLY_W = 16,
    parameter int IDX_W = $clog2(SB_N)
) (
    input  logic             axi_clk,
    input  logic             axi_rst_n,
    input  logic             arm,
    input  logic             ext_trig,
    input  logic             sw_trig,
    input  logic             release_i,
    input  logic [DLY_W-1:0] post_dly,
    input  logic [SB_N-1:0]  freeze_mask,
    input  logic             rd_ack,
    output logic [SB_N-1:0]  freeze,
    output logic             rd_req,
    output logic [IDX_W-1:0] rd_idx,
    output logic             done,
    output logic [2:0]       state_o,
    output logic [15:0]      cap_cnt
);
    // state | meaning
    // IDLE  | waiting for arm, nothing frozen
    // ARMED | mask latched, waiting for ext/sw trigger
    // POST  | post-trigger delay counting down to 1
    // SCAN  | buffers frozen, rd_idx walking over them
    // DONE  | readout finished, freeze held until release
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_POST  = 3'd2;
    localparam logic [2:0] ST_SCAN  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SB_N - 1);

    logic [2:0]       state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [SB_N-1:0]  mask_q, mask_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      cap_q, cap_d;
    logic             trig;
    logic             scan_step;

    assign trig      = ext_trig | sw_trig;
    assign scan_step = mask_q[idx_q] | rd_ack;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        // release wins over trigger and ack in every active state
        if (release_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        mask_d  = freeze_mask;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        if (cap_q != 16'hFFFF) cap_d = cap_q + 16'd1;
                        idx_d = '0;
                        if (post_dly == '0) begin
                            state_d = ST_SCAN;
                        end else begin
                            state_d = ST_POST;
                            cnt_d   = post_dly;
                        end
                    end
                end
                ST_POST: begin
                    cnt_d = cnt_q - DLY_W'(1);
                    if (cnt_q == DLY_W'(1)) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                    end
                end
                ST_SCAN: begin
                    if (scan_step) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: ;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
        end
    end

    // outputs are pure decodes of the registers above
    assign freeze  = ((state_q == ST_SCAN) || (state_q == ST_DONE)) ? ~mask_q : '0;
    assign rd_req  = (state_q == ST_SCAN) && !mask_q[idx_q];
    assign rd_idx  = idx_q;
    assign done    = (state_q == ST_DONE);
    assign state_o = state_q;
    assign cap_cnt = cap_q;

endmodule

// File: tb/tb_fm_sb_capture_seq.sv
`timescale 1ns/1ps
// Bench for fm_sb_capture_seq: directed vector table, a timed readout sequence,
// randomized traffic against a reference model, and cap_cnt saturation.
module tb_fm_sb_capture_seq;
    localparam int SB_N  = 4;
    localparam int DLY_W = 4;
    localparam int IDX_W = 2;

    logic             axi_clk, axi_rst_n, arm, ext_trig, sw_trig, release_i, rd_ack;
    logic [DLY_W-1:0] post_dly;
    logic [SB_N-1:0]  freeze_mask, freeze;
    logic             rd_req, done;
    logic [IDX_W-1:0] rd_idx;
    logic [2:0]       state_o;
    logic [15:0]      cap_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: spec state codes, remaining delay cycles, scan position
    int              m_st, m_wait, m_pos, m_cap;
    logic [SB_N-1:0] m_mask;

    fm_sb_capture_seq #(.SB_N(SB_N), .DLY_W(DLY_W), .IDX_W(IDX_W)) dut (
        .axi_clk(axi_clk), .axi_rst_n(axi_rst_n), .arm(arm), .ext_trig(ext_trig),
        .sw_trig(sw_trig), .release_i(release_i), .post_dly(post_dly),
        .freeze_mask(freeze_mask), .rd_ack(rd_ack), .freeze(freeze), .rd_req(rd_req),
        .rd_idx(rd_idx), .done(done), .state_o(state_o), .cap_cnt(cap_cnt)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish (got running, expected finished)");
        $fatal(1);
    end

    typedef struct {
        bit rn, a, e, s, r;
        logic [3:0] d, fm;
        bit ak;
        logic [2:0] st;
        logic [3:0] fz;
        bit req;
        logic [1:0] idx;
        bit dn;
        logic [15:0] cap;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rn, bit a, bit e, bit s, bit r, logic [3:0] d,
                                logic [3:0] fm, bit ak, logic [2:0] st, logic [3:0] fz,
                                bit req, logic [1:0] idx, bit dn, logic [15:0] cap);
        vec_t v;
        v.rn = rn; v.a = a; v.e = e; v.s = s; v.r = r; v.d = d; v.fm = fm; v.ak = ak;
        v.st = st; v.fz = fz; v.req = req; v.idx = idx; v.dn = dn; v.cap = cap;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(bit rn, bit a, bit e, bit s, bit r, logic [3:0] d,
                         logic [3:0] fm, bit ak);
        axi_rst_n = rn; arm = a; ext_trig = e; sw_trig = s; release_i = r;
        post_dly = d; freeze_mask = fm; rd_ack = ak;
    endtask

    task automatic model_step();
        if (!axi_rst_n) begin
            m_st = 0; m_wait = 0; m_pos = 0; m_mask = '0; m_cap = 0;
        end else if (release_i && m_st != 0) begin
            m_st = 0; m_pos = 0; m_wait = 0;
        end else begin
            case (m_st)
                0: if (arm) begin m_st = 1; m_mask = freeze_mask; end
                1: if (ext_trig || sw_trig) begin
                    if (m_cap < 65535) m_cap++;
                    m_pos = 0;
                    if (post_dly == 0) m_st = 3;
                    else begin m_st = 2; m_wait = int'(post_dly); end
                end
                2: begin
                    m_wait--;
                    if (m_wait == 0) begin m_st = 3; m_pos = 0; end
                end
                3: if (m_mask[m_pos] || rd_ack) begin
                    if (m_pos == SB_N - 1) begin m_st = 4; m_pos = 0; end
                    else m_pos++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_model(string tag);
        logic [SB_N-1:0] efz;
        efz = (m_st == 3 || m_st == 4) ? ~m_mask : '0;
        check({tag, "_state"}, state_o, m_st);
        check({tag, "_freeze"}, freeze, efz);
        check({tag, "_rd_req"}, rd_req, (m_st == 3 && !m_mask[m_pos]) ? 1 : 0);
        check({tag, "_rd_idx"}, rd_idx, m_pos);
        check({tag, "_done"}, done, (m_st == 4) ? 1 : 0);
        check({tag, "_cap_cnt"}, cap_cnt, m_cap);
    endtask

    task automatic cyc(string tag, bit rn, bit a, bit e, bit s, bit r, logic [3:0] d,
                       logic [3:0] fm, bit ak);
        drive(rn, a, e, s, r, d, fm, ak);
        @(posedge axi_clk);
        model_step();
        @(negedge axi_clk);
        compare_model(tag);
    endtask

    initial begin
        int first_fz;
        int seen[$];
        bit pending;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // rn a e s r d fm ack | st fz req idx dn cap
        tbl.push_back(mk(0,0,0,0,0,0,4'h0,0, 0,4'h0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,4'h5,0, 1,4'h0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,0,4'h0,0, 3,4'hA,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,0, 3,4'hA,1,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,0, 3,4'hA,1,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,1, 3,4'hA,0,2,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,1, 3,4'hA,1,3,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,1, 4,4'hA,0,0,1,1));
        tbl.push_back(mk(1,0,0,1,0,0,4'h0,0, 4,4'hA,0,0,1,1));
        tbl.push_back(mk(1,0,0,0,1,0,4'h0,0, 0,4'h0,0,0,0,1));
        tbl.push_back(mk(1,1,0,0,1,0,4'hF,0, 1,4'h0,0,0,0,1));
        tbl.push_back(mk(1,0,1,0,0,0,4'h0,0, 3,4'h0,0,0,0,2));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,0, 3,4'h0,0,1,0,2));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,0, 3,4'h0,0,2,0,2));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,0, 3,4'h0,0,3,0,2));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,0, 4,4'h0,0,0,1,2));
        tbl.push_back(mk(1,0,0,0,1,0,4'h0,0, 0,4'h0,0,0,0,2));
        tbl.push_back(mk(1,1,0,0,0,0,4'h0,0, 1,4'h0,0,0,0,2));
        tbl.push_back(mk(1,0,1,0,1,0,4'h0,0, 0,4'h0,0,0,0,2));
        tbl.push_back(mk(1,1,0,0,0,0,4'h0,0, 1,4'h0,0,0,0,2));
        tbl.push_back(mk(1,0,1,0,0,3,4'h0,0, 2,4'h0,0,0,0,3));
        tbl.push_back(mk(1,1,0,0,0,0,4'h0,0, 2,4'h0,0,0,0,3));
        tbl.push_back(mk(1,0,0,1,0,0,4'h0,0, 2,4'h0,0,0,0,3));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,0, 3,4'hF,1,0,0,3));
        tbl.push_back(mk(1,0,0,0,1,0,4'h0,1, 0,4'h0,0,0,0,3));
        tbl.push_back(mk(1,1,0,0,0,0,4'h0,0, 1,4'h0,0,0,0,3));
        tbl.push_back(mk(1,0,0,1,0,2,4'h0,0, 2,4'h0,0,0,0,4));
        tbl.push_back(mk(1,0,0,0,1,0,4'h0,0, 0,4'h0,0,0,0,4));
        tbl.push_back(mk(1,1,0,0,0,0,4'h0,0, 1,4'h0,0,0,0,4));
        tbl.push_back(mk(1,0,1,0,0,0,4'h0,0, 3,4'hF,1,0,0,5));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,1, 3,4'hF,1,1,0,5));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,1, 3,4'hF,1,2,0,5));
        tbl.push_back(mk(0,0,0,0,0,0,4'h0,1, 0,4'h0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,0, 0,4'h0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,4'h0,0, 1,4'h0,0,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,1,4'h0,0, 2,4'h0,0,0,0,1));
        tbl.push_back(mk(1,1,0,0,0,0,4'h0,0, 3,4'hF,1,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,1, 3,4'hF,1,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,1, 3,4'hF,1,2,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,1, 3,4'hF,1,3,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,4'h0,1, 4,4'hF,0,0,1,1));
        tbl.push_back(mk(1,1,0,1,0,0,4'h0,0, 4,4'hF,0,0,1,1));
        tbl.push_back(mk(1,0,0,0,1,0,4'h0,0, 0,4'h0,0,0,0,1));

        foreach (tbl[i]) begin
            drive(tbl[i].rn, tbl[i].a, tbl[i].e, tbl[i].s, tbl[i].r, tbl[i].d,
                  tbl[i].fm, tbl[i].ak);
            @(posedge axi_clk);
            @(negedge axi_clk);
            check($sformatf("vec%0d_state", i), state_o, tbl[i].st);
            check($sformatf("vec%0d_freeze", i), freeze, tbl[i].fz);
            check($sformatf("vec%0d_rd_req", i), rd_req, tbl[i].req);
            check($sformatf("vec%0d_rd_idx", i), rd_idx, tbl[i].idx);
            check($sformatf("vec%0d_done", i), done, tbl[i].dn);
            check($sformatf("vec%0d_cap_cnt", i), cap_cnt, tbl[i].cap);
        end

        // arm in cycle 0, ext_trig in cycle 10 with D=3: freeze first high in cycle 14
        drive(0, 0, 0, 0, 0, 3, 4'h0, 0);
        @(posedge axi_clk);
        @(negedge axi_clk);
        first_fz = -1;
        for (int c = 0; c <= 20; c++) begin
            drive(1, c == 0, c == 10, 0, 0, 3, 4'h0, 0);
            @(posedge axi_clk);
            @(negedge axi_clk);
            if (first_fz < 0 && freeze == 4'hF) first_fz = c + 1;
        end
        check("seq_freeze_first_cycle", first_fz, 14);
        pending = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (pending) begin
                rd_ack = 1'b1;
                pending = 0;
            end else begin
                rd_ack = 1'b0;
                if (rd_req) begin
                    seen.push_back(int'(rd_idx));
                    pending = 1;
                end
            end
            @(posedge axi_clk);
            @(negedge axi_clk);
        end
        rd_ack = 1'b0;
        check("seq_req_count", seen.size(), 4);
        foreach (seen[i]) check($sformatf("seq_req%0d_idx", i), seen[i], i);
        check("seq_done", done, 1);
        check("seq_cap_cnt", cap_cnt, 1);

        cyc("rnd_reset", 0, 0, 0, 0, 0, 0, 4'h0, 0);
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] fm;
            int sel;
            sel = $urandom_range(0, 3);
            fm = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(0, 15));
            cyc("rnd", $urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 19) == 0, 4'($urandom_range(0, 5)), fm,
                $urandom_range(0, 1) == 1);
        end

        // preload the capture counter near its ceiling, then capture twice
        cyc("sat_reset", 0, 0, 0, 0, 0, 0, 4'h0, 0);
        force dut.cap_q = 16'hFFFE;
        #1;
        release dut.cap_q;
        m_cap = 65534;
        check("sat_preload", cap_cnt, 16'hFFFE);
        cyc("sat_arm1", 1, 1, 0, 0, 0, 0, 4'h0, 0);
        cyc("sat_trig1", 1, 0, 1, 0, 0, 0, 4'h0, 0);
        check("sat_first", cap_cnt, 16'hFFFF);
        cyc("sat_rel1", 1, 0, 0, 0, 1, 0, 4'h0, 0);
        cyc("sat_arm2", 1, 1, 0, 0, 0, 0, 4'h0, 0);
        cyc("sat_trig2", 1, 0, 0, 1, 0, 2, 4'h0, 0);
        check("sat_hold", cap_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
